// File: rtl/memory_access.sv
// Memory-stage load/store unit: latches LDUR/STUR requests from execute, runs the
// req/gnt/rvalid handshake with data memory and stalls the pipe until completion.
// Optional bus-wait timeout is compiled in with `define LSU_TIMEOUT_EN.
module memory_access #(
  parameter int N              = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  output logic         stall_M,
  output logic         done_M,
  output logic [N-1:0] readData_M,
  output logic         fault_M,
  output logic         busError_M,
  output logic         memReq,
  output logic         memWe,
  output logic [N-1:0] memAddr,
  output logic [N-1:0] memWdata,
  input  logic         memGnt,
  input  logic         memRValid,
  input  logic [N-1:0] memRdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e         state_q;
  logic           req_q;
  logic           we_q;
  logic [N-1:0]   addr_q;
  logic [N-1:0]   wdata_q;
  logic [N-1:0]   rdata_q;
  logic           done_q;
  logic           fault_q;
  logic           busErr_q;

  logic           opValid;
  logic           opBad;
  logic           opGood;
  logic           timeoutHit;

  // A request is only legal when doubleword aligned and exactly one direction is set.
  assign opValid = valid_E & (memRead_E | memWrite_E);
  assign opBad   = opValid & ((|aluResult_E[2:0]) | (memRead_E & memWrite_E));
  assign opGood  = opValid & ~opBad;

`ifdef LSU_TIMEOUT_EN
  localparam int              CntW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q;

  assign timeoutHit = (cnt_q == CntLimit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (!timeoutHit) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Completion is checked before the timeout so a response on the limit cycle still wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      busErr_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      busErr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (opBad) begin
            fault_q <= 1'b1;
          end else if (opGood) begin
            addr_q  <= aluResult_E;
            wdata_q <= writeData_E;
            we_q    <= memWrite_E;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (memGnt) begin
            req_q <= 1'b0;
            if (we_q) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end else if (timeoutHit) begin
            req_q    <= 1'b0;
            busErr_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        WAIT: begin
          if (memRValid) begin
            rdata_q <= memRdata;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (timeoutHit) begin
            busErr_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall_M    = (state_q != IDLE);
  assign done_M     = done_q;
  assign readData_M = rdata_q;
  assign fault_M    = fault_q;
  assign busError_M = busErr_q;
  assign memReq     = req_q;
  assign memWe      = we_q;
  assign memAddr    = addr_q;
  assign memWdata   = wdata_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed and randomized operations checked
// against a transaction-level schedule model of the load/store unit.
module tb_memory_access;

  localparam int N  = 64;
  localparam int TO = 8;

  logic         clk;
  logic         reset;
  logic         valid_E;
  logic         memRead_E;
  logic         memWrite_E;
  logic [N-1:0] aluResult_E;
  logic [N-1:0] writeData_E;
  logic         stall_M;
  logic         done_M;
  logic [N-1:0] readData_M;
  logic         fault_M;
  logic         busError_M;
  logic         memReq;
  logic         memWe;
  logic [N-1:0] memAddr;
  logic [N-1:0] memWdata;
  logic         memGnt;
  logic         memRValid;
  logic [N-1:0] memRdata;

  int           passCount  = 0;
  int           totalCount = 0;
  logic [N-1:0] lastLoad;

  memory_access #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_E    (valid_E),
    .memRead_E  (memRead_E),
    .memWrite_E (memWrite_E),
    .aluResult_E(aluResult_E),
    .writeData_E(writeData_E),
    .stall_M    (stall_M),
    .done_M     (done_M),
    .readData_M (readData_M),
    .fault_M    (fault_M),
    .busError_M (busError_M),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memWdata   (memWdata),
    .memGnt     (memGnt),
    .memRValid  (memRValid),
    .memRdata   (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic driveIdle();
    valid_E     = 1'b0;
    memRead_E   = 1'b0;
    memWrite_E  = 1'b0;
    aluResult_E = '0;
    writeData_E = '0;
    memGnt      = 1'b0;
    memRValid   = 1'b0;
    memRdata    = '0;
  endtask

  // Presents one operation in the current (idle) cycle and plays the bus side with
  // grant g cycles after the first request cycle and read data r cycles after entering
  // the wait phase. Expected outputs come from the op's schedule: a store finishes
  // at cycle 2+g, a load at 3+g+r, a fault/ignored op occupies just cycle 1.
  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [N-1:0] addr, input logic [N-1:0] data,
                               input int g, input int r, input logic [N-1:0] rdata);
    bit bad, access, isLoad;
    int lastCyc;
    bad     = v && (rd || wr) && ((addr[2:0] != 3'b000) || (rd && wr));
    access  = v && (rd || wr) && !bad;
    isLoad  = access && rd;
    lastCyc = !access ? 1 : (isLoad ? 3 + g + r : 2 + g);

    valid_E     = v;
    memRead_E   = rd;
    memWrite_E  = wr;
    aluResult_E = addr;
    writeData_E = data;
    memGnt      = 1'($urandom % 2);
    memRValid   = 1'($urandom % 2);
    memRdata    = {$urandom, $urandom};

    for (int c = 1; c <= lastCyc; c++) begin
      @(negedge clk);
      valid_E     = (c < lastCyc) ? 1'($urandom % 2) : 1'b0;
      memRead_E   = 1'($urandom % 2);
      memWrite_E  = 1'($urandom % 2);
      aluResult_E = {$urandom, $urandom} & ~64'h7;
      writeData_E = {$urandom, $urandom};
      if (access && c <= 1 + g)   memGnt = (c == 1 + g);
      else if (c == lastCyc)      memGnt = 1'($urandom % 2);
      else                        memGnt = 1'b0;
      if (isLoad && c > 1 + g && c < lastCyc) memRValid = (c == lastCyc - 1);
      else if (access && c <= 1 + g)          memRValid = 1'($urandom % 2);
      else if (c == lastCyc)                  memRValid = 1'($urandom % 2);
      else                                    memRValid = 1'b0;
      memRdata = (isLoad && c == lastCyc - 1) ? rdata : {$urandom, $urandom};

      if (isLoad && c == lastCyc) lastLoad = rdata;

      checkOutput("stall_M",    stall_M,    N'(access && c < lastCyc));
      checkOutput("memReq",     memReq,     N'(access && c <= 1 + g));
      checkOutput("done_M",     done_M,     N'(access && c == lastCyc));
      checkOutput("fault_M",    fault_M,    N'(bad && c == 1));
      checkOutput("busError_M", busError_M, '0);
      checkOutput("readData_M", readData_M, lastLoad);
      if (access && c <= 1 + g) begin
        checkOutput("memAddr",  memAddr,  addr);
        checkOutput("memWe",    memWe,    N'(wr));
        checkOutput("memWdata", memWdata, data);
      end
    end
  endtask

  initial begin
    driveIdle();
    reset    = 1'b1;
    lastLoad = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_stall",    stall_M,    '0);
    checkOutput("rst_done",     done_M,     '0);
    checkOutput("rst_fault",    fault_M,    '0);
    checkOutput("rst_busError", busError_M, '0);
    checkOutput("rst_memReq",   memReq,     '0);
    checkOutput("rst_memWe",    memWe,      '0);
    checkOutput("rst_memAddr",  memAddr,    '0);
    checkOutput("rst_memWdata", memWdata,   '0);
    checkOutput("rst_readData", readData_M, '0);
    reset = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b1, 64'h10, 64'hDEADBEEF, 0, 0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h28, 64'h5555, 2, 2, 64'h123);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h2C, 64'h0, 0, 0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h40, 64'h77, 0, 0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h48, 64'h99, 0, 0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h50, 64'h0, 0, 0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h60, 64'hCAFE, 0, 0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h68, 64'h0, 0, 0, 64'hFEEDF00D);

    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] a;
      logic         v, rd, wr;
      int           kind;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
      kind = $urandom_range(0, 9);
      v    = ($urandom_range(0, 9) != 0);
      rd   = (kind == 1) || (kind >= 2 && kind <= 5);
      wr   = (kind == 1) || (kind >= 6);
      applyStimulus(v, rd, wr, a, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
    end

    // Reset while a load waits for its response; the late response must be dropped.
    driveIdle();
    valid_E     = 1'b1;
    memRead_E   = 1'b1;
    aluResult_E = 64'h80;
    @(negedge clk);
    driveIdle();
    memGnt = 1'b1;
    checkOutput("rstw_req_memReq", memReq, 64'd1);
    @(negedge clk);
    memGnt = 1'b0;
    checkOutput("rstw_wait_stall",  stall_M, 64'd1);
    checkOutput("rstw_wait_memReq", memReq,  '0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstw_async_memReq", memReq,     '0);
    checkOutput("rstw_async_stall",  stall_M,    '0);
    checkOutput("rstw_async_done",   done_M,     '0);
    checkOutput("rstw_async_rdata",  readData_M, '0);
    lastLoad = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      memRValid = 1'b1;
      memRdata  = {$urandom, $urandom};
      @(negedge clk);
      checkOutput("rstw_late_done",  done_M,     '0);
      checkOutput("rstw_late_stall", stall_M,    '0);
      checkOutput("rstw_late_rdata", readData_M, lastLoad);
    end
    driveIdle();

    applyStimulus(1'b1, 1'b1, 1'b0, 64'h90, 64'h0, 1, 1, 64'hABCDEF01);

    // Store that is never granted.
    valid_E     = 1'b1;
    memWrite_E  = 1'b1;
    aluResult_E = 64'h100;
    writeData_E = 64'h4242;
`ifdef LSU_TIMEOUT_EN
    begin
      int   errSeen;
      int   errCycle;
      int   doneSeen;
      logic stallAtErr;
      errSeen    = 0;
      errCycle   = -1;
      doneSeen   = 0;
      stallAtErr = 1'b1;
      for (int c = 1; c <= 4 * TO; c++) begin
        @(negedge clk);
        driveIdle();
        if (busError_M === 1'b1) begin
          errSeen++;
          if (errCycle < 0) begin
            errCycle   = c;
            stallAtErr = stall_M;
          end
        end
        if (done_M === 1'b1) doneSeen++;
      end
      checkOutput("to_pulse_count", N'(errSeen), 64'd1);
      checkOutput("to_stall_fell",  N'(stallAtErr), '0);
      checkOutput("to_cycle_range", N'(errCycle >= TO && errCycle <= TO + 2), 64'd1);
      checkOutput("to_no_done",     N'(doneSeen), '0);
      checkOutput("to_rdata_kept",  readData_M, lastLoad);
      checkOutput("to_memReq_low",  memReq, '0);
    end
`else
    begin
      int okCycles;
      okCycles = 0;
      for (int c = 1; c <= 4 * TO; c++) begin
        @(negedge clk);
        driveIdle();
        if (stall_M === 1'b1 && memReq === 1'b1 && busError_M === 1'b0 && done_M === 1'b0)
          okCycles++;
      end
      checkOutput("stuck_wait_cycles", N'(okCycles), N'(4 * TO));
      #2 reset = 1'b1;
      #1;
      checkOutput("stuck_rst_memReq", memReq,  '0);
      checkOutput("stuck_rst_stall",  stall_M, '0);
      lastLoad = '0;
      @(negedge clk);
      reset = 1'b0;
    end
`endif

    applyStimulus(1'b1, 1'b0, 1'b1, 64'h200, 64'h1234, 1, 0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h208, 64'h0, 0, 3, 64'h0BADC0DE);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
